// File: rtl/wb_pkg.sv
// Writeback stage shared types: result source enum, load funct3 codes
// and the load alignment/extension helper.
package wb_pkg;

  typedef enum logic [2:0] {
    SRC_ALU   = 3'd0,
    SRC_LOAD  = 3'd1,
    SRC_PC4   = 3'd2,
    SRC_PCTGT = 3'd3,
    SRC_IMM   = 3'd4
  } result_src_e;

  localparam int NUM_SRC_DEF = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Returns {err, data}; data is built at 64 bits and trimmed for xlen=32.
  function automatic logic [64:0] load_extend(
    input logic [63:0] raw,
    input logic [2:0]  funct3,
    input logic [1:0]  off,
    input int          xlen
  );
    logic [63:0] sh;
    logic [63:0] d;
    logic        e;
    sh = raw >> {off, 3'b000};
    d  = '0;
    e  = 1'b0;
    case (funct3)
      F3_LB:  d = {{56{sh[7]}}, sh[7:0]};
      F3_LBU: d = {56'b0, sh[7:0]};
      F3_LH: begin
        if (off == 2'd3) e = 1'b1;
        else d = {{48{sh[15]}}, sh[15:0]};
      end
      F3_LHU: begin
        if (off == 2'd3) e = 1'b1;
        else d = {48'b0, sh[15:0]};
      end
      F3_LW: begin
        if (off != 2'd0) e = 1'b1;
        else d = {{32{sh[31]}}, sh[31:0]};
      end
      default: e = 1'b1;
    endcase
    if (xlen == 32) d[63:32] = '0;
    return {e, d};
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load byte/halfword/word alignment and sign/zero extension.
// Misaligned or undefined loads produce zero data with err set.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [63:0] raw64;
  logic [64:0] r;

  always_comb begin
    raw64 = 64'(raw);
    r     = load_extend(raw64, funct3, off, XLEN);
    data  = r[XLEN-1:0];
    err   = r[64];
  end

  if (XLEN < 64) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^r[63:XLEN];
  end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback result stage: source select, load extension, registered
// result behind a valid/ready handshake and a retired-instruction counter.
module wb_result_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        result_src,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [2:0]              load_funct3,
  input  logic [1:0]              byte_off,
  input  logic [4:0]              rd_addr,
  input  logic                    reg_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_result,
  output logic [4:0]              out_rd,
  output logic                    out_reg_write,
  output logic                    out_err,
  output logic [CNT_W-1:0]        retire_cnt
);

  logic [XLEN-1:0] ld_data;
  logic            ld_err;
  logic [XLEN-1:0] sel_data;
  logic            sel_err;
  logic            sel_we;
  logic            accept;
  logic            retire;

  wb_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .raw    (src_data[int'(SRC_LOAD)*XLEN +: XLEN]),
    .funct3 (load_funct3),
    .off    (byte_off),
    .data   (ld_data),
    .err    (ld_err)
  );

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    if (int'(result_src) >= NUM_SRC) begin
      sel_err = 1'b1;
    end else if (int'(result_src) == int'(SRC_LOAD)) begin
      sel_data = ld_data;
      sel_err  = ld_err;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (int'(result_src) == i) sel_data = src_data[i*XLEN +: XLEN];
      end
    end
    sel_we = reg_write && !sel_err && (rd_addr != 5'd0);
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_err       <= 1'b0;
      retire_cnt    <= '0;
    end else begin
      if (accept) begin
        out_valid     <= 1'b1;
        out_result    <= sel_data;
        out_rd        <= rd_addr;
        out_reg_write <= sel_we;
        out_err       <= sel_err;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed table, backpressure/reset sequences,
// random traffic against a scoreboard model, and a 64-bit/4-bit-counter DUT.
module tb_wb_result_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   result_src;
  logic [159:0] src_data;
  logic [2:0]   load_funct3;
  logic [1:0]   byte_off;
  logic [4:0]   rd_addr;
  logic         reg_write;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_result;
  logic [4:0]   out_rd;
  logic         out_reg_write;
  logic         out_err;
  logic [31:0]  retire_cnt;

  logic         in_valid2;
  logic         in_ready2;
  logic [2:0]   result_src2;
  logic [319:0] src_data2;
  logic [2:0]   load_funct3_2;
  logic [1:0]   byte_off2;
  logic [4:0]   rd_addr2;
  logic         reg_write2;
  logic         out_valid2;
  logic         out_ready2;
  logic [63:0]  out_result2;
  logic [4:0]   out_rd2;
  logic         out_reg_write2;
  logic         out_err2;
  logic [3:0]   retire_cnt2;

  logic [31:0] srcs [5];
  assign src_data = {srcs[4], srcs[3], srcs[2], srcs[1], srcs[0]};

  always #5 clk = ~clk;

  wb_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .result_src(result_src), .src_data(src_data),
    .load_funct3(load_funct3), .byte_off(byte_off),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_err(out_err),
    .retire_cnt(retire_cnt)
  );

  wb_result_stage #(.XLEN(64), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .result_src(result_src2), .src_data(src_data2),
    .load_funct3(load_funct3_2), .byte_off(byte_off2),
    .rd_addr(rd_addr2), .reg_write(reg_write2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_result(out_result2), .out_rd(out_rd2),
    .out_reg_write(out_reg_write2), .out_err(out_err2),
    .retire_cnt(retire_cnt2)
  );

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic        we;
  } mres_t;

  // Reference model straight from the load/select rules, plain arithmetic.
  function automatic mres_t model(int src, longint unsigned w, int f3,
                                  int off, int rd, bit rw, int xlen);
    mres_t r;
    longint unsigned sh, v;
    r.err = 1'b0;
    v = 0;
    if (src >= 5) r.err = 1'b1;
    else if (src != 1) v = w;
    else begin
      sh = w >> (8 * off);
      case (f3)
        0: begin v = sh % 256; if (v >= 128) v = v - 256; end
        4: v = sh % 256;
        1: if (off == 3) r.err = 1'b1;
           else begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
        5: if (off == 3) r.err = 1'b1; else v = sh % 65536;
        2: if (off != 0) r.err = 1'b1;
           else begin
             v = sh % (64'd1 << 32);
             if (xlen == 64 && v >= (64'd1 << 31)) v = v - (64'd1 << 32);
           end
        default: r.err = 1'b1;
      endcase
    end
    if (r.err) v = 0;
    if (xlen == 32) v = v % (64'd1 << 32);
    r.res = v;
    r.we  = rw && !r.err && (rd != 0);
    return r;
  endfunction

  logic        m_valid = 1'b0;
  longint      m_cnt = 0;
  logic [63:0] m_res = '0;
  logic        m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;

  task automatic tick();
    bit acc;
    mres_t r;
    acc = in_valid && (!m_valid || out_ready);
    if (!rst_n) begin
      m_valid = 0; m_cnt = 0; m_res = 0; m_err = 0; m_we = 0; m_rd = 0;
    end else begin
      if (m_valid && out_ready) m_cnt++;
      if (acc) begin
        r = model(int'(result_src),
                  (int'(result_src) < 5) ? 64'(srcs[result_src]) : 64'd0,
                  int'(load_funct3), int'(byte_off), int'(rd_addr),
                  reg_write, 32);
        m_valid = 1; m_res = r.res; m_err = r.err; m_we = r.we;
        m_rd = rd_addr;
      end else if (m_valid && out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("sb_valid", 64'(out_valid), 64'(m_valid));
    chk("sb_ready", 64'(in_ready), 64'(!m_valid || out_ready));
    chk("sb_cnt", 64'(retire_cnt), 64'(m_cnt % (64'd1 << 32)));
    chk("sb_result", 64'(out_result), m_res);
    chk("sb_err", 64'(out_err), 64'(m_err));
    chk("sb_we", 64'(out_reg_write), 64'(m_we));
    chk("sb_rd", 64'(out_rd), 64'(m_rd));
  endtask

  task automatic drive(input int src, input logic [31:0] d, input int f3,
                       input int off, input int rd, input bit rw);
    for (int i = 0; i < 5; i++) srcs[i] = $urandom;
    if (src < 5) srcs[src] = d;
    in_valid = 1'b1;
    result_src = 3'(src);
    load_funct3 = 3'(f3);
    byte_off = 2'(off);
    rd_addr = 5'(rd);
    reg_write = rw;
  endtask

  typedef struct {
    int          src;
    logic [31:0] d;
    int          f3;
    int          off;
    int          rd;
    bit          rw;
    logic [31:0] exp_res;
    bit          exp_err;
    bit          exp_we;
  } vec_t;

  vec_t vt [12];
  logic [31:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    result_src = '0; load_funct3 = '0; byte_off = '0;
    rd_addr = '0; reg_write = 1'b0;
    for (int i = 0; i < 5; i++) srcs[i] = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; result_src2 = 3'd1;
    src_data2 = '0; src_data2[64 +: 64] = 64'h0000_0000_8000_0000;
    load_funct3_2 = 3'b010; byte_off2 = 2'd0; rd_addr2 = 5'd4;
    reg_write2 = 1'b1;

    vt[0]  = '{1, 32'h80FF7F01, 0, 1, 3, 1, 32'h0000007F, 0, 1};
    vt[1]  = '{1, 32'h80FF7F01, 0, 3, 3, 1, 32'hFFFFFF80, 0, 1};
    vt[2]  = '{1, 32'h80FF7F01, 5, 2, 3, 1, 32'h000080FF, 0, 1};
    vt[3]  = '{1, 32'h80FF7F01, 1, 2, 3, 1, 32'hFFFF80FF, 0, 1};
    vt[4]  = '{1, 32'h80FF7F01, 2, 0, 3, 1, 32'h80FF7F01, 0, 1};
    vt[5]  = '{1, 32'h80FF7F01, 4, 0, 3, 1, 32'h00000001, 0, 1};
    vt[6]  = '{1, 32'h80FF7F01, 1, 3, 3, 1, 32'h00000000, 1, 0};
    vt[7]  = '{7, 32'h80FF7F01, 2, 0, 3, 1, 32'h00000000, 1, 0};
    vt[8]  = '{1, 32'h80FF7F01, 3, 0, 3, 1, 32'h00000000, 1, 0};
    vt[9]  = '{1, 32'h80FF7F01, 2, 2, 3, 1, 32'h00000000, 1, 0};
    vt[10] = '{4, 32'h00000123, 0, 0, 0, 1, 32'h00000123, 0, 0};
    vt[11] = '{3, 32'hDEADBEEF, 0, 0, 9, 1, 32'hDEADBEEF, 0, 1};

    tick();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_cnt", 64'(retire_cnt), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_valid2", 64'(out_valid2), 64'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream with out_ready held high.
    out_ready = 1'b1;
    drive(0, 32'h11, 0, 0, 5, 1); tick();
    chk("s1_a", 64'(out_result), 64'h11);
    drive(0, 32'h22, 0, 0, 5, 1); tick();
    chk("s1_b", 64'(out_result), 64'h22);
    drive(0, 32'h33, 0, 0, 5, 1); tick();
    chk("s1_c", 64'(out_result), 64'h33);
    chk("s1_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; tick();
    chk("s1_cnt", 64'(retire_cnt), 64'd3);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].src, vt[i].d, vt[i].f3, vt[i].off, vt[i].rd, vt[i].rw);
      tick();
      chk($sformatf("vec%0d_res", i), 64'(out_result), 64'(vt[i].exp_res));
      chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_we", i), 64'(out_reg_write), 64'(vt[i].exp_we));
    end
    in_valid = 1'b0; tick();

    // Backpressure: hold for 4 cycles, then release with a new input.
    out_ready = 1'b0;
    drive(2, 32'hA5A5_0004, 0, 0, 7, 1); tick();
    held = out_result;
    chk("bp_load", 64'(held), 64'hA5A5_0004);
    for (int i = 0; i < 4; i++) begin
      drive(0, $urandom, 0, 0, 8, 1); tick();
      chk("bp_hold", 64'(out_result), 64'(held));
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    drive(0, 32'h5555_1234, 0, 0, 9, 1); tick();
    chk("bp_reload_valid", 64'(out_valid), 64'd1);
    chk("bp_reload_res", 64'(out_result), 64'h5555_1234);
    in_valid = 1'b0; tick();

    // x0 write, then reset while a result is stalled.
    out_ready = 1'b0;
    drive(4, 32'h123, 0, 0, 0, 1); tick();
    chk("x0_res", 64'(out_result), 64'h123);
    chk("x0_we", 64'(out_reg_write), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b0; tick();
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_res", 64'(out_result), 64'd0);
    chk("rst_mid_cnt", 64'(retire_cnt), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1; tick();

    // Random traffic against the scoreboard.
    for (int n = 0; n < 300; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive($urandom_range(0, 7), $urandom, $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 31),
              1'($urandom_range(0, 1)));
      else in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; tick();

    // 64-bit LW sign extension and 4-bit counter wrap.
    in_valid2 = 1'b1; tick();
    chk("w64_lw", out_result2, 64'hFFFF_FFFF_8000_0000);
    chk("w64_err", 64'(out_err2), 64'd0);
    chk("w64_we", 64'(out_reg_write2), 64'd1);
    for (int i = 0; i < 16; i++) tick();
    chk("wrap_16", 64'(retire_cnt2), 64'd0);
    in_valid2 = 1'b0; tick();
    chk("wrap_17", 64'(retire_cnt2), 64'd1);
    chk("wrap_valid", 64'(out_valid2), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
Parametrised writeback result stage for the pipelined core generation.
- Selects one of NUM_SRC result sources.
- Applies load byte/halfword alignment and sign/zero extension.
- Registers the result with destination register and write-enable behind a valid/ready handshake.
- Keeps a retired-instruction counter.
- Sits between the MEM stage and the register file write port. Replaces the combinational result select of the single-cycle core.

Parameters:
XLEN, 32, datapath width in bits (32 or 64).
NUM_SRC, 5, number of result sources; index order fixed by package enum.
SEL_W, $clog2(NUM_SRC), width of source select (derived, not overridden).
CNT_W, 32, width of retire counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage can accept this cycle
result_src  in  SEL_W  source index (SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_PCTGT=3, SRC_IMM=4)
src_data  in  NUM_SRC*XLEN  packed sources; source i at bits [i*XLEN +: XLEN]
load_funct3  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101)
byte_off  in  2  address bits [1:0] of the load
rd_addr  in  5  destination register
reg_write  in  1  instruction writes rd
out_valid  out  1  registered result valid
out_ready  in  1  register file/downstream accepts
out_result  out  XLEN  registered result
out_rd  out  5  registered destination
out_reg_write  out  1  registered write enable
out_err  out  1  registered error flag for this result
retire_cnt  out  CNT_W  count of completed handshakes on the output

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid, out_result, out_rd, out_reg_write, out_err and retire_cnt all become 0.
  - in_ready is 1 during the first cycle after reset.
  - Reset overrides any handshake in the same cycle, including mid-transfer.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no skid).
  - Accept occurs when in_valid && in_ready. Latency is 1 cycle; throughput is 1 per cycle while out_ready is held high.
  - Output holds stable while out_valid && !out_ready.
  - out_valid clears on an output handshake with no simultaneous accept.
  - Simultaneous output handshake and input accept: the register reloads and out_valid stays 1.
- Source select:
  - Index < NUM_SRC: data = src_data slice.
  - Index >= NUM_SRC: data = 0, err = 1.
- Load path (SRC_LOAD only):
  - raw = src_data slice >> (byte_off*8).
  - LB / LBU: sign- / zero-extend raw[7:0] to XLEN.
  - LH / LHU: sign- / zero-extend raw[15:0].
  - LW: raw[31:0] when XLEN=32; sign-extended when XLEN=64.
  - Halfword with byte_off=3, word with byte_off!=0, or an undefined funct3: data = 0, err = 1.
- Write enable: out_reg_write = reg_write && !err && (rd_addr != 0). Writes to x0 are suppressed and are not errors.
- out_err is registered together with the result and has no sticky state.
- retire_cnt increments by 1 on each out_valid && out_ready. It wraps modulo 2^CNT_W with no saturation.
- Inputs other than in_valid are don't-care when in_valid=0. The register does not load when there is no accept.

Decomposition:
- Package wb_pkg holds:
  - result_src_e enum (SRC_ALU … SRC_IMM) and NUM_SRC_DEF.
  - load_funct3 localparams.
  - Function load_extend(raw, funct3, off, XLEN) returning {err, data}.
- One natural sub-module, wb_load_align. It is combinational alignment and extension instantiated on the SRC_LOAD slice, and is unit-testable alone.
- Select, handshake register and counter stay in wb_result_stage.

Test Plan:
1. Reset then stream: out_ready=1 with 3 back-to-back inputs of SRC_ALU (0x11, 0x22, 0x33), rd=5 -> outputs 0x11, 0x22, 0x33 on consecutive cycles 1 cycle after each input; retire_cnt=3; in_ready stays 1.
2. Loads: src LOAD=0x80FF7F01, LB off=1 -> 0x0000007F; LB off=3 -> 0xFFFFFF80; LHU off=2 -> 0x000080FF; LH off=2 -> 0xFFFF80FF; LW off=0 -> 0x80FF7F01; all with out_err=0.
3. Errors: LH off=3 -> result 0, out_err=1, out_reg_write=0; result_src=7 with NUM_SRC=5 -> same response; funct3=011 -> same response.
4. Backpressure: out_ready=0 for 4 cycles after an accept -> out_result stable and in_ready=0 throughout. Raise out_ready together with a new in_valid -> out_valid stays 1, new data appears the next cycle, and retire_cnt increments once.
5. x0 write and reset: rd=0, reg_write=1, SRC_IMM=0x123 -> out_result=0x123, out_reg_write=0. Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle all outputs are 0 and in_ready=1.
6. Wrap and width: CNT_W=4, 17 completions -> retire_cnt=1. XLEN=64, LW of 0x80000000 -> 0xFFFFFFFF80000000.
